// File: rtl/uart_pkg.sv
// Shared types and widths for the UART receive path.
package uart_pkg;
   localparam int unsigned BYTE_W = 8;

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} rx_state_t;
endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser plus mid-bit sampling FSM.
// Emits a one-cycle push strobe with the assembled byte, or a frame_err pulse.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_PER_HALF_BIT = 5208
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rxd,
   output logic [BYTE_W-1:0] data,
   output logic              push,
   output logic              frame_err
);
   localparam int unsigned CNT_W = (2 * CLK_PER_HALF_BIT > 1) ? $clog2(2 * CLK_PER_HALF_BIT) : 1;
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_HALF_BIT - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(2 * CLK_PER_HALF_BIT - 1);

   logic              sync1, rxs;
   rx_state_t         state, state_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic [2:0]        bitn, bitn_nx;
   logic [BYTE_W-1:0] shift, shift_nx;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= 1'b1;
         rxs   <= 1'b1;
         state <= IDLE;
         cnt   <= '0;
         bitn  <= '0;
         shift <= '0;
      end else begin
         sync1 <= rxd;
         rxs   <= sync1;
         state <= state_nx;
         cnt   <= cnt_nx;
         bitn  <= bitn_nx;
         shift <= shift_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt + CNT_W'(1);
      bitn_nx   = bitn;
      shift_nx  = shift;
      push      = 1'b0;
      frame_err = 1'b0;
      unique case (state)
         IDLE: begin
            cnt_nx = '0;
            if (!rxs) state_nx = START;
         end
         START: begin
            // A start bit that is high again at its midpoint is a glitch.
            if (cnt == HALF_LAST) begin
               cnt_nx   = '0;
               bitn_nx  = '0;
               state_nx = rxs ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == BIT_LAST) begin
               cnt_nx         = '0;
               shift_nx[bitn] = rxs;
               bitn_nx        = bitn + 3'd1;
               if (bitn == 3'd7) state_nx = STOP;
            end
         end
         STOP: begin
            if (cnt == BIT_LAST) begin
               cnt_nx = '0;
               if (rxs) begin
                  push     = 1'b1;
                  state_nx = IDLE;
               end else begin
                  frame_err = 1'b1;
                  state_nx  = WAIT_IDLE;
               end
            end
         end
         WAIT_IDLE: begin
            cnt_nx = '0;
            if (rxs) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign data = shift;
endmodule

// File: rtl/in_controller.sv
// Receive path: UART bytes buffered in a FIFO, delivered to the core
// (stall handshake, fall-through head) or to the bootloader (registered strobe).
module in_controller
   import uart_pkg::*;
#(
   parameter int unsigned CLK_PER_HALF_BIT = 5208,
   parameter int unsigned DEPTH            = 4096
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rxd,
   input  logic              boot_mode,
   input  logic              read,
   output logic [BYTE_W-1:0] dout_core,
   output logic              stall,
   output logic [BYTE_W-1:0] dout_bootloader,
   output logic              valid_bootloader,
   output logic              overrun,
   output logic              frame_err
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [BYTE_W-1:0] rx_data;
   logic              rx_push, rx_ferr;

   uart_rx #(.CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)) u_rx (
      .clk       (clk),
      .reset     (reset),
      .rxd       (rxd),
      .data      (rx_data),
      .push      (rx_push),
      .frame_err (rx_ferr)
   );

   logic [BYTE_W-1:0] mem [DEPTH];
   logic [AW:0]       wr_ptr, rd_ptr;
   logic              empty, full, pop_core, pop_boot, pop, wr_en;
   logic [BYTE_W-1:0] head;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head     = mem[rd_ptr[AW-1:0]];
   assign stall    = read & (empty | boot_mode);
   assign pop_core = read & ~stall;
   assign pop_boot = boot_mode & ~empty;
   assign pop      = pop_core | pop_boot;
   // A simultaneous pop frees the slot, so full is judged after the pop.
   assign wr_en    = rx_push & (~full | pop);
   assign dout_core = empty ? '0 : head;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= rx_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         dout_bootloader  <= '0;
         valid_bootloader <= 1'b0;
         overrun          <= 1'b0;
         frame_err        <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         valid_bootloader <= pop_boot;
         if (pop_boot) dout_bootloader <= head;
         if (rx_push && !wr_en) overrun <= 1'b1;
         if (rx_ferr) frame_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_in_controller.sv
// Self-checking bench for in_controller: drives UART frames on rxd and compares
// core/bootloader deliveries and sticky flags with a queue-based model.
module tb_in_controller;
   localparam int unsigned CPHB    = 4;
   localparam int unsigned DEPTH   = 4;
   localparam int          BIT_CYC = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rxd = 1'b1;
   logic       boot_mode = 1'b0;
   logic       read = 1'b0;
   logic [7:0] dout_core, dout_bootloader;
   logic       stall, valid_bootloader, overrun, frame_err;

   int n_checks = 0;
   int n_errors = 0;

   byte unsigned fifo_q[$];
   byte unsigned boot_exp[$];
   byte unsigned boot_got[$];
   bit exp_ovr = 1'b0;
   bit exp_ferr = 1'b0;

   in_controller #(.CLK_PER_HALF_BIT(CPHB), .DEPTH(DEPTH)) dut (
      .clk              (clk),
      .reset            (reset),
      .rxd              (rxd),
      .boot_mode        (boot_mode),
      .read             (read),
      .dout_core        (dout_core),
      .stall            (stall),
      .dout_bootloader  (dout_bootloader),
      .valid_bootloader (valid_bootloader),
      .overrun          (overrun),
      .frame_err        (frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (valid_bootloader === 1'b1) boot_got.push_back(dout_bootloader);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int gap);
      rxd = 1'b0;
      tick(BIT_CYC);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         tick(BIT_CYC);
      end
      rxd = stop_ok;
      tick(BIT_CYC);
      rxd = 1'b1;
      tick(gap);
      if (!stop_ok) exp_ferr = 1'b1;
      else if (boot_mode) boot_exp.push_back(b);
      else if (fifo_q.size() < DEPTH) fifo_q.push_back(b);
      else exp_ovr = 1'b1;
   endtask

   task automatic read_expect(input string tag);
      byte unsigned e;
      read = 1'b1;
      @(negedge clk);
      if (fifo_q.size() == 0) begin
         check_eq({tag, "_stall"}, stall, 1);
      end else begin
         e = fifo_q.pop_front();
         check_eq({tag, "_stall"}, stall, 0);
         check_eq({tag, "_data"}, dout_core, e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_flags(input string tag);
      check_eq({tag, "_overrun"}, overrun, exp_ovr);
      check_eq({tag, "_frame_err"}, frame_err, exp_ferr);
   endtask

   task automatic check_boot(input string tag);
      int n;
      check_eq({tag, "_boot_cnt"}, boot_got.size(), boot_exp.size());
      n = (boot_got.size() < boot_exp.size()) ? boot_got.size() : boot_exp.size();
      for (int i = 0; i < n; i++) check_eq({tag, "_boot_data"}, boot_got[i], boot_exp[i]);
      boot_got.delete();
      boot_exp.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      rxd = 1'b1;
      read = 1'b0;
      tick(2);
      reset = 1'b0;
      fifo_q.delete();
      boot_exp.delete();
      boot_got.delete();
      exp_ovr = 1'b0;
      exp_ferr = 1'b0;
      tick(4);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int k;
      logic [7:0] cap;
      int unsigned r;
      logic [7:0] rb;
      bit rstop;
      int nrd;

      // Reset values
      tick(3);
      @(negedge clk);
      check_eq("rst_dout_core", dout_core, 0);
      check_eq("rst_stall", stall, 0);
      check_eq("rst_dout_boot", dout_bootloader, 0);
      check_eq("rst_valid_boot", valid_bootloader, 0);
      check_eq("rst_overrun", overrun, 0);
      check_eq("rst_frame_err", frame_err, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      tick(4);

      // 1: byte waits in FIFO, read pops it, next read stalls
      send_byte(8'hA5, 1'b1, 4);
      read_expect("t1");
      read_expect("t1_empty");
      read = 1'b0;

      // 2: read pending on empty FIFO until the byte lands
      read = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check_eq("t2_stall_empty", stall, 1);
      end
      @(posedge clk);
      #1;
      k = 0;
      cap = '0;
      fork
         send_byte(8'h3C, 1'b1, 4);
         begin
            while (k < 200) begin
               @(negedge clk);
               if (!stall) break;
               k++;
            end
            check_eq("t2_wait_stall", stall, 0);
            cap = dout_core;
            check_eq("t2_latency_ok", (k >= 76 && k <= 82), 1);
            @(negedge clk);
            check_eq("t2_stall_after", stall, 1);
         end
      join
      read = 1'b0;
      check_eq("t2_model_has_byte", fifo_q.size(), 1);
      if (fifo_q.size() > 0) check_eq("t2_data", cap, fifo_q.pop_front());

      // 3: bootloader path, back-to-back frames
      boot_mode = 1'b1;
      read = 1'b1;
      send_byte(8'h01, 1'b1, 0);
      send_byte(8'h02, 1'b1, 0);
      send_byte(8'h03, 1'b1, 8);
      @(negedge clk);
      check_eq("t3_stall_boot", stall, 1);
      @(posedge clk);
      #1;
      check_boot("t3");
      boot_mode = 1'b0;
      read = 1'b0;
      tick(2);

      // 4: overrun on fifth byte
      for (int i = 0; i < 5; i++) send_byte(8'(8'h10 + i), 1'b1, 4);
      check_flags("t4");
      for (int i = 0; i < 5; i++) read_expect("t4_rd");
      read = 1'b0;

      // 5: bad stop bit, then a good frame
      send_byte(8'h7E, 1'b0, 8);
      check_flags("t5_err");
      send_byte(8'h42, 1'b1, 4);
      read_expect("t5_rd");
      read_expect("t5_empty");
      read = 1'b0;

      // 6: glitch, then reset mid-frame, then clean frame
      do_reset();
      rxd = 1'b0;
      tick(2);
      rxd = 1'b1;
      tick(20);
      read_expect("t6_glitch");
      read = 1'b0;
      check_flags("t6_glitch");
      rxd = 1'b0;
      tick(BIT_CYC);
      rxd = 1'b1;
      tick(BIT_CYC);
      rxd = 1'b0;
      tick(BIT_CYC + 4);
      do_reset();
      tick(10);
      send_byte(8'h99, 1'b1, 4);
      read_expect("t6_rd");
      read_expect("t6_empty");
      read = 1'b0;
      check_flags("t6_flags");

      // Randomised traffic with mode switches
      for (int it = 0; it < 25; it++) begin
         r = $urandom_range(0, 7);
         rb = 8'($urandom);
         rstop = ($urandom_range(0, 7) != 0);
         if (r == 0 && !boot_mode) begin
            boot_mode = 1'b1;
            while (fifo_q.size() > 0) boot_exp.push_back(fifo_q.pop_front());
         end else if (r == 1) begin
            boot_mode = 1'b0;
         end
         send_byte(rb, rstop, int'($urandom_range(0, 6)));
         tick(4);
         if (!boot_mode) begin
            nrd = int'($urandom_range(0, 2));
            for (int j = 0; j < nrd; j++) read_expect("rnd_rd");
            read = 1'b0;
         end
         check_flags("rnd");
         check_boot("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/in_controller.md
Name: in_controller

Overview:
Receive-side counterpart of the output path. Deserialises 8N1 UART bytes from the rxd pin and buffers them in a FIFO. Delivers them to the core's read (input) instruction with a stall handshake, or to the bootloader while boot_mode is high. Sits between the board RX pin and the core/bootloader input muxes.

Parameters:
CLK_PER_HALF_BIT, 5208, clock cycles per half UART bit; one bit period = 2*CLK_PER_HALF_BIT.
DEPTH, 4096, FIFO depth in bytes; must be a power of two, at least 2.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
rxd  input  1  UART serial input, idle high, asynchronous to clk
boot_mode  input  1  1: bytes go to the bootloader port; 0: bytes go to the core port
read  input  1  core read request; held until not stalled
dout_core  output  8  head byte; valid when read=1 and stall=0
stall  output  1  core must hold the pipeline this cycle
dout_bootloader  output  8  byte for the bootloader
valid_bootloader  output  1  one-cycle strobe; dout_bootloader valid
overrun  output  1  sticky; a byte was dropped because the FIFO was full
frame_err  output  1  sticky; a stop bit was sampled low

Behaviour:
- Reset (async) sets all outputs to 0, empties the FIFO, puts the RX FSM in IDLE and sets both synchroniser flops to 1.
- rxd passes through a 2-flop synchroniser; the FSM sees only the synchronised value rxs.
- RX FSM states IDLE, START, DATA, STOP, WAIT_IDLE. A single counter cnt counts cycles; bitn (0..7) counts data bits.
- IDLE: when rxs=0, go to START with cnt=0.
- START: when cnt reaches CLK_PER_HALF_BIT-1 (mid start bit), sample rxs.
  - rxs=0: go to DATA with cnt=0, bitn=0.
  - rxs=1: treat as a glitch and return to IDLE with no error.
- DATA: sample rxs into shift[bitn] (LSB first) every 2*CLK_PER_HALF_BIT cycles. After bitn=7, go to STOP.
- STOP: sample at mid stop bit, 2*CLK_PER_HALF_BIT cycles after the last data sample.
  - rxs=1: push the byte to the FIFO and return to IDLE.
  - rxs=0: discard the byte, set frame_err, go to WAIT_IDLE.
- WAIT_IDLE: stay until rxs=1, then go to IDLE.
- Push on full: the byte is dropped and overrun is set. If a pop happens in the same cycle, the push is accepted, because full is evaluated after the pop.
- FIFO: circular buffer with log2(DEPTH)+1-bit wr/rd pointers.
  - empty when the pointers are equal.
  - full when the MSBs differ and the rest are equal.
  - Pointers wrap naturally at DEPTH.
- Push→visible latency: a byte pushed at edge N is readable from cycle N+1. There is no same-cycle bypass.
- Core path (boot_mode=0):
  - First-word-fall-through: dout_core equals the FIFO head combinationally.
  - stall = read & (empty | boot_mode).
  - When read=1 and stall=0, the head is popped at the next clk edge.
- Bootloader path (boot_mode=1):
  - When not empty, pop one byte per cycle.
  - dout_bootloader and valid_bootloader are registered: the byte appears with valid_bootloader=1 on the cycle after the pop.
  - The core cannot pop while boot_mode=1.
- boot_mode change: allowed at any time. It takes effect on the next cycle and must not lose or duplicate a byte.
- Reset mid-frame: the partial byte is discarded and the FSM returns to IDLE. The next falling edge after release starts a new frame.
- overrun and frame_err clear only on reset.

Decomposition:
- Shared package (uart_pkg): enum rx_state_t {IDLE, START, DATA, STOP, WAIT_IDLE} and the BYTE_W=8 constant.
- One natural sub-module, uart_rx (synchroniser + FSM). It outputs an 8-bit data value, a 1-cycle push strobe and a frame_err pulse. FIFO and read arbitration stay in in_controller.

Test Plan:
All scenarios use CLK_PER_HALF_BIT=4 (bit period 8 cycles) and DEPTH=4.
1. Receive 0xA5 with read=0 and boot_mode=0 → after about 76 cycles empty=0. Then read=1 → stall=0, dout_core=0xA5 the same cycle; the next cycle stall=1.
2. read=1 with the FIFO empty for 20 cycles, then send 0x3C → stall=1 until the cycle after the push, then dout_core=0x3C with stall=0 for one cycle.
3. boot_mode=1, send 0x01, 0x02, 0x03 back-to-back → three valid_bootloader pulses with data 0x01, 0x02, 0x03 in order. read=1 throughout → stall=1.
4. Send 5 bytes 0x10–0x14 with no reads → overrun=1. Subsequent reads return 0x10, 0x11, 0x12, 0x13, then stall (0x14 was dropped).
5. Send a frame with 0x7E data and stop bit=0 → frame_err=1, no push. The next valid frame 0x42 is received correctly.
6. A 2-cycle low glitch on rxd → no push, no error. Assert reset mid-data-bit, release, send 0x99 → only 0x99 is received and all flags are 0.
